// File: rtl/capture_ctrl_if.sv
// capture_ctrl_if: command, sample-handshake and status bundle for capture_ctrl.
//   master modport: controller's client (drives commands, observes status).
//   slave modport : capture_ctrl itself.
//   Commands : cmd_start, cmd_abort, post_count, cap_triggered, tmo_cycles
//   Stream   : s_valid, s_ready (a beat is s_valid & s_ready)
//   Status   : arm, abort, frame_last, state, done, aborted, timed_out, beat_count
interface capture_ctrl_if #(
  parameter int saddr_w = 24,
  parameter int tmo_w   = 32
);
  logic               cmd_start;
  logic               cmd_abort;
  logic [saddr_w-1:0] post_count;
  logic               cap_triggered;
  logic               s_valid;
  logic               s_ready;
  logic [tmo_w-1:0]   tmo_cycles;
  logic               arm;
  logic               abort;
  logic               frame_last;
  logic [1:0]         state;
  logic               done;
  logic               aborted;
  logic               timed_out;
  logic [saddr_w-1:0] beat_count;

  modport master (
    output cmd_start, cmd_abort, post_count, cap_triggered, s_valid, s_ready, tmo_cycles,
    input  arm, abort, frame_last, state, done, aborted, timed_out, beat_count
  );

  modport slave (
    input  cmd_start, cmd_abort, post_count, cap_triggered, s_valid, s_ready, tmo_cycles,
    output arm, abort, frame_last, state, done, aborted, timed_out, beat_count
  );
endinterface

// File: rtl/capture_ctrl.sv
// capture_ctrl: arm / trigger / post-trigger sequencing for a sample capture engine.
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high
//   bus   : capture_ctrl_if.slave (commands, sample handshake, status)
// Optional feature: define CAPTURE_CTRL_TIMEOUT_EN to build the arm timeout.
// Without it tmo_cycles is ignored and timed_out is tied to 0.
//
// state | meaning
// IDLE  | waiting for cmd_start
// ARMED | waiting for cap_triggered (optionally bounded by tmo_cycles)
// POST  | forwarding post_count beats; frame_last on the final one
// DONE  | capture complete; cmd_start re-arms
module capture_ctrl #(
  parameter int saddr_w = 24,
  parameter int tmo_w   = 32
) (
  input  logic          clk,
  input  logic          reset,
  capture_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             st;
  logic [saddr_w-1:0] remaining;
  logic [saddr_w-1:0] beat_cnt;
  logic               abort_r;
  logic               done_r;
  logic               aborted_r;
  logic               beat;

  assign beat = bus.s_valid & bus.s_ready;

`ifdef CAPTURE_CTRL_TIMEOUT_EN
  logic [tmo_w-1:0] tmo_cnt;
  logic             timed_out_r;
  logic             tmo_hit;

  // Count of completed ARMED cycles; expiry on the tmo_cycles-th one.
  assign tmo_hit = (bus.tmo_cycles != '0) && (tmo_cnt == bus.tmo_cycles - tmo_w'(1));
  assign bus.timed_out = timed_out_r;
`else
  logic [tmo_w-1:0] unused_tmo;
  assign unused_tmo    = bus.tmo_cycles;
  assign bus.timed_out = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st        <= IDLE;
      remaining <= '0;
      beat_cnt  <= '0;
      abort_r   <= 1'b0;
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
`ifdef CAPTURE_CTRL_TIMEOUT_EN
      tmo_cnt     <= '0;
      timed_out_r <= 1'b0;
`endif
    end else begin
      abort_r <= 1'b0;
      case (st)
        IDLE, DONE: begin
          if (bus.cmd_start) begin
            st        <= ARMED;
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
            beat_cnt  <= '0;
            remaining <= '0;
`ifdef CAPTURE_CTRL_TIMEOUT_EN
            tmo_cnt     <= '0;
            timed_out_r <= 1'b0;
`endif
          end
        end
        ARMED: begin
          if (bus.cmd_abort) begin
            st        <= IDLE;
            abort_r   <= 1'b1;
            aborted_r <= 1'b1;
`ifdef CAPTURE_CTRL_TIMEOUT_EN
          end else if (tmo_hit) begin
            st          <= IDLE;
            abort_r     <= 1'b1;
            timed_out_r <= 1'b1;
`endif
          end else if (bus.cap_triggered) begin
            if (bus.post_count == '0) begin
              st     <= DONE;
              done_r <= 1'b1;
            end else begin
              st        <= POST;
              remaining <= bus.post_count;
            end
          end else begin
`ifdef CAPTURE_CTRL_TIMEOUT_EN
            tmo_cnt <= tmo_cnt + tmo_w'(1);
`endif
          end
        end
        POST: begin
          if (bus.cmd_abort) begin
            st        <= IDLE;
            abort_r   <= 1'b1;
            aborted_r <= 1'b1;
            remaining <= '0;
          end else if (beat) begin
            if (remaining != '0) remaining <= remaining - saddr_w'(1);
            if (beat_cnt != '1) beat_cnt <= beat_cnt + saddr_w'(1);
            if (remaining == saddr_w'(1)) begin
              st     <= DONE;
              done_r <= 1'b1;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  // Status decodes come from registers only, so nothing here depends on inputs.
  assign bus.state      = st;
  assign bus.arm        = (st == ARMED);
  assign bus.frame_last = (st == POST) && (remaining == saddr_w'(1));
  assign bus.abort      = abort_r;
  assign bus.done       = done_r;
  assign bus.aborted    = aborted_r;
  assign bus.beat_count = beat_cnt;

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: directed self-checking bench for capture_ctrl.
module tb_capture_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  logic q_last[$];
  int   q_cnt[$];

  capture_ctrl_if #(.saddr_w(24), .tmo_w(32)) bus ();
  capture_ctrl #(.saddr_w(24), .tmo_w(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    bus.cmd_start = 1'b1; tick(); bus.cmd_start = 1'b0;
  endtask

  task automatic pulse_trig();
    bus.cap_triggered = 1'b1; tick(); bus.cap_triggered = 1'b0;
  endtask

  // Expectations go into the scoreboard as the beat is driven and are
  // retired when the DUT presents frame_last and then the updated count.
  task automatic do_beat(input logic exp_last, input int exp_cnt);
    q_last.push_back(exp_last);
    q_cnt.push_back(exp_cnt);
    bus.s_valid = 1'b1; bus.s_ready = 1'b1;
    check("beat_frame_last", 32'(bus.frame_last), 32'(q_last.pop_front()));
    tick();
    bus.s_valid = 1'b0; bus.s_ready = 1'b0;
    check("beat_count", 32'(bus.beat_count), 32'(q_cnt.pop_front()));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.cmd_start = 0; bus.cmd_abort = 0; bus.post_count = '0; bus.cap_triggered = 0;
    bus.s_valid = 0; bus.s_ready = 0; bus.tmo_cycles = '0;
    tick(); tick();
    check("rst_state", 32'(bus.state), 0);
    check("rst_arm", 32'(bus.arm), 0);
    check("rst_abort", 32'(bus.abort), 0);
    check("rst_frame_last", 32'(bus.frame_last), 0);
    check("rst_flags", {29'd0, bus.done, bus.aborted, bus.timed_out}, 0);
    check("rst_beat_count", 32'(bus.beat_count), 0);
    reset = 1'b0;
    tick();

    // Ignored inputs in IDLE
    pulse_trig();
    check("idle_trig_ignored", 32'(bus.state), 0);
    bus.cmd_abort = 1'b1; tick(); bus.cmd_abort = 1'b0;
    check("idle_abort_nop_state", 32'(bus.state), 0);
    check("idle_abort_no_pulse", 32'(bus.abort), 0);
    check("idle_abort_no_flag", 32'(bus.aborted), 0);

    // post_count=4 full capture
    bus.post_count = 24'd4;
    pulse_start();
    check("armed_state", 32'(bus.state), 1);
    check("armed_arm", 32'(bus.arm), 1);
    bus.s_valid = 1'b1; bus.s_ready = 1'b1; tick(); bus.s_valid = 0; bus.s_ready = 0;
    check("armed_beat_not_counted", 32'(bus.beat_count), 0);
    pulse_trig();
    check("post_state", 32'(bus.state), 2);
    check("post_arm_low", 32'(bus.arm), 0);
    pulse_start();
    check("post_start_ignored", 32'(bus.state), 2);
    do_beat(1'b0, 1);
    bus.s_valid = 1'b1; bus.s_ready = 1'b0; tick(); bus.s_valid = 0;
    check("stall_no_count", 32'(bus.beat_count), 1);
    do_beat(1'b0, 2);
    do_beat(1'b0, 3);
    do_beat(1'b1, 4);
    check("p4_state", 32'(bus.state), 3);
    check("p4_done", 32'(bus.done), 1);
    check("p4_frame_last_off", 32'(bus.frame_last), 0);
    bus.s_valid = 1'b1; bus.s_ready = 1'b1; tick(); bus.s_valid = 0; bus.s_ready = 0;
    check("done_beat_not_counted", 32'(bus.beat_count), 4);
    bus.cmd_abort = 1'b1; tick(); bus.cmd_abort = 1'b0;
    check("done_abort_nop", {30'd0, bus.state}, 3);
    check("done_abort_no_pulse", 32'(bus.abort), 0);

    // post_count=0: trigger goes straight to DONE
    bus.post_count = 24'd0;
    pulse_start();
    check("p0_restart_clears_done", 32'(bus.done), 0);
    check("p0_restart_clears_count", 32'(bus.beat_count), 0);
    check("p0_frame_last_armed", 32'(bus.frame_last), 0);
    pulse_trig();
    check("p0_state", 32'(bus.state), 3);
    check("p0_done", 32'(bus.done), 1);
    check("p0_frame_last", 32'(bus.frame_last), 0);
    check("p0_beats", 32'(bus.beat_count), 0);

    // post_count=8, 3 beats, abort coinciding with a beat
    bus.post_count = 24'd8;
    pulse_start();
    pulse_trig();
    do_beat(1'b0, 1);
    do_beat(1'b0, 2);
    do_beat(1'b0, 3);
    bus.cmd_abort = 1'b1; bus.s_valid = 1'b1; bus.s_ready = 1'b1;
    tick();
    bus.cmd_abort = 1'b0; bus.s_valid = 1'b0; bus.s_ready = 1'b0;
    check("abrt_state", 32'(bus.state), 0);
    check("abrt_pulse", 32'(bus.abort), 1);
    check("abrt_flag", 32'(bus.aborted), 1);
    check("abrt_beat_count", 32'(bus.beat_count), 3);
    tick();
    check("abrt_pulse_one_cycle", 32'(bus.abort), 0);

    // abort and trigger together in ARMED
    pulse_start();
    check("restart_clears_aborted", 32'(bus.aborted), 0);
    bus.cmd_abort = 1'b1; bus.cap_triggered = 1'b1;
    tick();
    bus.cmd_abort = 1'b0; bus.cap_triggered = 1'b0;
    check("abrt_trig_state", 32'(bus.state), 0);
    check("abrt_trig_flag", 32'(bus.aborted), 1);
    check("abrt_trig_pulse", 32'(bus.abort), 1);

    // Arm timeout
    bus.tmo_cycles = 32'd10;
    pulse_start();
    for (int i = 0; i < 9; i++) tick();
    check("tmo_still_armed", 32'(bus.state), 1);
    tick();
`ifdef CAPTURE_CTRL_TIMEOUT_EN
    check("tmo_state", 32'(bus.state), 0);
    check("tmo_flag", 32'(bus.timed_out), 1);
    check("tmo_pulse", 32'(bus.abort), 1);
    tick();
    check("tmo_pulse_one_cycle", 32'(bus.abort), 0);
    check("tmo_not_aborted", 32'(bus.aborted), 0);
    bus.tmo_cycles = 32'd0;
    pulse_start();
    check("tmo_restart_clears", 32'(bus.timed_out), 0);
`endif
    for (int i = 0; i < 40; i++) tick();
    check("no_tmo_armed", 32'(bus.state), 1);
    check("no_tmo_flag", 32'(bus.timed_out), 0);
    bus.cmd_abort = 1'b1; tick(); bus.cmd_abort = 1'b0;
    bus.tmo_cycles = 32'd0;

    // Asynchronous reset mid-POST with remaining=5
    pulse_start();
    pulse_trig();
    do_beat(1'b0, 1);
    do_beat(1'b0, 2);
    do_beat(1'b0, 3);
    check("pre_rst_state", 32'(bus.state), 2);
    #2 reset = 1'b1;
    #1;
    check("arst_state", 32'(bus.state), 0);
    check("arst_arm_abort_last", {29'd0, bus.arm, bus.abort, bus.frame_last}, 0);
    check("arst_flags", {29'd0, bus.done, bus.aborted, bus.timed_out}, 0);
    check("arst_beat_count", 32'(bus.beat_count), 0);
    tick();
    reset = 1'b0;
    tick();
    pulse_trig();
    check("post_rst_needs_start", 32'(bus.state), 0);
    bus.post_count = 24'd2;
    pulse_start();
    check("post_rst_rearm", 32'(bus.state), 1);
    pulse_trig();
    do_beat(1'b0, 1);
    do_beat(1'b1, 2);
    check("post_rst_done", {30'd0, bus.state}, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 Parameter saddr_w, default 24: width of the post-trigger count and beat counters.
REQ-002 Parameter tmo_w, default 32: width of the arm-timeout counter.
REQ-003 clk  in  1  single clock; all logic synchronous to its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 cmd_start  in  1  one-cycle request to arm a capture.
REQ-006 cmd_abort  in  1  one-cycle request to abandon the current capture.
REQ-007 post_count  in  saddr_w  number of samples to forward after the trigger.
REQ-008 cap_triggered  in  1  trigger-hit indication from the capture engine.
REQ-009 s_valid  in  1  sample-stream valid; s_ready  in  1  sample-stream ready (beat = s_valid & s_ready).
REQ-010 tmo_cycles  in  tmo_w  arm timeout in clk cycles; 0 disables the timeout.
REQ-011 arm  out  1  level; high while in ARMED.
REQ-012 abort  out  1  one-cycle pulse to the capture engine.
REQ-013 frame_last  out  1  marks the final post-trigger beat (tlast source).
REQ-014 state  out  2  encoding IDLE=0, ARMED=1, POST=2, DONE=3.
REQ-015 done / aborted / timed_out  out  1 each  sticky status flags.
REQ-016 beat_count  out  saddr_w  beats accepted in POST since the last arm.

Function
REQ-017 The FSM SHALL have the states IDLE, ARMED, POST and DONE, all transitions taking effect on the clock edge.
REQ-018 In IDLE or DONE, cmd_start SHALL enter ARMED, clear done/aborted/timed_out, and zero beat_count and the timeout counter.
REQ-019 In ARMED or POST, cmd_start SHALL be ignored.
REQ-020 In ARMED, cap_triggered=1 SHALL enter POST and load remaining=post_count; if post_count=0, the FSM SHALL enter DONE directly and set done.
REQ-021 In POST, each beat SHALL decrement remaining and increment beat_count; a beat with remaining=1 SHALL enter DONE and set done.
REQ-022 frame_last SHALL equal (state==POST) & (remaining==1), decoded from registers only, with no combinational path from inputs.
REQ-023 remaining SHALL be saddr_w bits wide and SHALL never wrap below 0; beat_count SHALL saturate at its all-ones value.
REQ-024 cmd_abort in ARMED or POST SHALL return the FSM to IDLE, pulse abort for exactly one cycle (the cycle after cmd_abort), and set aborted.
REQ-025 cmd_abort in IDLE or DONE SHALL be a no-op with no abort pulse.
REQ-026 Priority on the same cycle SHALL be: cmd_abort > timeout > cap_triggered / beat > cmd_start.
REQ-027 cap_triggered outside ARMED SHALL be ignored; beats outside POST SHALL not be counted.

Reset
REQ-028 Asserting reset SHALL immediately force state=IDLE, arm=0, abort=0, frame_last=0, all flags=0, beat_count=0, remaining=0 and timeout counter=0, including in the middle of a capture.
REQ-029 The first transition after reset deassertion SHALL require a fresh cmd_start.

Configuration
REQ-030 With CAPTURE_CTRL_TIMEOUT_EN defined, the timeout SHALL behave as follows:
- ARMED counts clk cycles.
- When the count reaches tmo_cycles (tmo_cycles nonzero) with no trigger, the FSM SHALL enter IDLE, pulse abort for one cycle and set timed_out.
REQ-031 Without CAPTURE_CTRL_TIMEOUT_EN:
- The timeout counter SHALL not be built.
- tmo_cycles SHALL be ignored.
- timed_out SHALL be tied to 0.

Verification
REQ-032 post_count=4, start, trigger, 4 beats -> frame_last high on the 4th beat only; done=1; beat_count=4; state=3.
REQ-033 post_count=0, start, trigger -> DONE on the next edge with no beats forwarded and frame_last never asserted.
REQ-034 post_count=8, trigger, 3 beats, then cmd_abort with s_valid&s_ready on the same cycle -> abort pulse of 1 cycle; state=0; aborted=1; beat_count=3.
REQ-035 cmd_abort and cap_triggered in the same ARMED cycle -> IDLE, not POST; aborted=1.
REQ-036 With the macro and tmo_cycles=10, start with no trigger -> IDLE after 10 cycles, timed_out=1, one abort pulse; tmo_cycles=0 -> remains ARMED indefinitely.
REQ-037 reset asserted mid-POST (remaining=5) -> all outputs at their reset values asynchronously; cmd_start afterwards re-arms normally.
